shift_chain_arbiter: RTL and testbench

- Shares one serial shift chain (serial data in, shift enable, parallel latch strobe) between two requesters that each present a parallel word.
- Round-robin arbiter plus serializer FSM: grants one requester, shifts its word MSB-first into the chain over WIDTH cycles, then pulses a latch strobe.
- Sits between word-producing logic and the shared 4-bit shift chain.

---
 rtl/shift_chain_arbiter.sv | 105 ++++++++++
 tb/tb_shift_chain_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/shift_chain_arbiter.sv
// Round-robin arbiter and MSB-first serializer sharing one shift chain between
// two word producers; each word is shifted over WIDTH cycles, then latched.
module shift_chain_arbiter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  input  logic [WIDTH-1:0] req_data0,
  input  logic [WIDTH-1:0] req_data1,
  output logic [1:0]       req_ready,
  output logic             ser_out,
  output logic             shift_en,
  output logic             load_strobe,
  output logic             owner,
  output logic             busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] LATCH = 2'd2;

  logic [1:0]       state;
  logic             last;
  logic [WIDTH-1:0] buffer;
  logic [CNT_W-1:0] cnt;
  logic             grant;
  logic             accept;
  logic [WIDTH-1:0] grant_data;

  // On contention the requester that did not win last time goes first.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grant = 1'b0;
    if (req_valid == 2'b11)
      grant = ~last;
    else if (req_valid[1])
      grant = 1'b1;
  end

  always_comb begin
    req_ready = 2'b00;
    if (state == IDLE && req_valid[grant])
      req_ready[grant] = 1'b1;
  end

  assign accept     = |(req_valid & req_ready);
  assign grant_data = grant ? req_data1 : req_data0;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last        <= 1'b1;
      buffer      <= '0;
      cnt         <= '0;
      ser_out     <= 1'b0;
      shift_en    <= 1'b0;
      load_strobe <= 1'b0;
      owner       <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            buffer   <= grant_data;
            owner    <= grant;
            last     <= grant;
            cnt      <= '0;
            state    <= SHIFT;
            shift_en <= 1'b1;
            ser_out  <= grant_data[WIDTH-1];
            busy     <= 1'b1;
          end
        end
        SHIFT: begin
          // ser_out already shows buffer[WIDTH-1]; present the next bit down.
          buffer <= {buffer[WIDTH-2:0], 1'b0};
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state       <= LATCH;
            shift_en    <= 1'b0;
            ser_out     <= 1'b0;
            load_strobe <= 1'b1;
          end else begin
            ser_out <= buffer[WIDTH-2];
          end
        end
        LATCH: begin
          state       <= IDLE;
          load_strobe <= 1'b0;
          busy        <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          shift_en    <= 1'b0;
          load_strobe <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_chain_arbiter.sv
// Self-checking bench for shift_chain_arbiter: vector table plus directed
// sequences, with a serial-bit / owner scoreboard drained by a monitor.
module tb_shift_chain_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid;
  logic [3:0] req_data0;
  logic [3:0] req_data1;
  logic [1:0] req_ready;
  logic       ser_out;
  logic       shift_en;
  logic       load_strobe;
  logic       owner;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;
  bit mon_en      = 1'b0;

  logic bit_q[$];
  logic owner_q[$];

  typedef struct {
    logic [1:0] valid;
    logic [3:0] d0;
    logic [3:0] d1;
    logic [1:0] exp_ready;
    logic       exp_owner;
  } vec_t;

  vec_t vecs[9];

  shift_chain_arbiter #(.WIDTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid),
    .req_data0(req_data0), .req_data1(req_data1), .req_ready(req_ready),
    .ser_out(ser_out), .shift_en(shift_en), .load_strobe(load_strobe),
    .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [3:0] d, input logic o);
    for (int i = 3; i >= 0; i--) bit_q.push_back(d[i]);
    owner_q.push_back(o);
  endtask

  // Inputs are driven at negedge+1; this returns at negedge+1 with busy low.
  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 20) check("wait_idle_timeout", 8'(busy), 8'd0);
  endtask

  // Monitor: invariants every cycle, serial bits and latch owner against the scoreboard.
  always begin
    @(negedge clk); #3;
    if (mon_en) begin
      check("shift_and_strobe", 8'(shift_en & load_strobe), 8'd0);
      if (busy === 1'b1) check("ready_while_busy", 8'(req_ready), 8'd0);
      check("ready_onehot", 8'(req_ready == 2'b11), 8'd0);
      if (shift_en === 1'b1) begin
        if (bit_q.size() == 0) check("unexpected_shift", 8'(shift_en), 8'd0);
        else check("ser_out", 8'(ser_out), 8'(bit_q.pop_front()));
      end
      if (load_strobe === 1'b1) begin
        if (owner_q.size() == 0) check("unexpected_strobe", 8'(load_strobe), 8'd0);
        else check("strobe_owner", 8'(owner), 8'(owner_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Pointer starts at last=1, so requester 0 wins the first contention.
    vecs[0] = '{2'b01, 4'hB, 4'h0, 2'b01, 1'b0};
    vecs[1] = '{2'b10, 4'h0, 4'hF, 2'b10, 1'b1};
    vecs[2] = '{2'b11, 4'hA, 4'h5, 2'b01, 1'b0};
    vecs[3] = '{2'b11, 4'h2, 4'h9, 2'b10, 1'b1};
    vecs[4] = '{2'b10, 4'h1, 4'h3, 2'b10, 1'b1};
    vecs[5] = '{2'b11, 4'h6, 4'h8, 2'b01, 1'b0};
    vecs[6] = '{2'b01, 4'hC, 4'h7, 2'b01, 1'b0};
    vecs[7] = '{2'b11, 4'h4, 4'hE, 2'b10, 1'b1};
    vecs[8] = '{2'b00, 4'hD, 4'hD, 2'b00, 1'b0};

    rst = 1'b1; req_valid = 2'b00; req_data0 = 4'h0; req_data1 = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_ser_out", 8'(ser_out), 8'd0);
    check("rst_shift_en", 8'(shift_en), 8'd0);
    check("rst_strobe", 8'(load_strobe), 8'd0);
    check("rst_busy", 8'(busy), 8'd0);
    check("rst_owner", 8'(owner), 8'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Single word 1011 from requester 0 with cycle-exact output checks.
    req_valid = 2'b01; req_data0 = 4'b1011;
    #1 check("t1_ready", 8'(req_ready), 8'b01);
    push_word(4'b1011, 1'b0);
    @(negedge clk); #1;
    req_valid = 2'b00;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) begin @(negedge clk); #1; end
      check("t1_shift_en", 8'(shift_en), 8'(k <= 4));
      check("t1_strobe", 8'(load_strobe), 8'(k == 5));
      check("t1_busy", 8'(busy), 8'(k <= 5));
      if (k == 5) check("t1_owner", 8'(owner), 8'd0);
    end

    // Vector table: arbitration, then inputs scrambled mid-transfer.
    for (int v = 0; v < 9; v++) begin
      wait_idle();
      req_valid = vecs[v].valid; req_data0 = vecs[v].d0; req_data1 = vecs[v].d1;
      #1 check($sformatf("vec%0d_ready", v), 8'(req_ready), 8'(vecs[v].exp_ready));
      if (vecs[v].exp_ready != 2'b00)
        push_word(vecs[v].exp_owner ? vecs[v].d1 : vecs[v].d0, vecs[v].exp_owner);
      @(negedge clk); #1;
      req_valid = 2'b00; req_data0 = ~req_data0; req_data1 = ~req_data1;
    end

    // Both held valid: alternate 0,1,0,1 with a handshake every 6 cycles.
    wait_idle();
    req_valid = 2'b11; req_data0 = 4'hA; req_data1 = 4'h5;
    for (int w = 0; w < 4; w++) begin
      for (int c = 0; c < 6; c++) begin
        #1;
        if (c == 0) begin
          check("b2b_ready", 8'(req_ready), (w % 2 == 0) ? 8'b01 : 8'b10);
          push_word((w % 2 == 0) ? 4'hA : 4'h5, 1'(w % 2));
        end else begin
          check("b2b_ready_idle", 8'(req_ready), 8'd0);
        end
        @(negedge clk); #1;
      end
    end
    req_valid = 2'b00;

    // Abort in the 2nd SHIFT cycle after a grant to requester 0 (last=0).
    wait_idle();
    req_valid = 2'b01; req_data0 = 4'hD;
    #1 check("abort_ready", 8'(req_ready), 8'b01);
    push_word(4'hD, 1'b0);
    @(negedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    bit_q.delete(); owner_q.delete();
    @(negedge clk); #1;
    check("abort_ser_out", 8'(ser_out), 8'd0);
    check("abort_shift_en", 8'(shift_en), 8'd0);
    check("abort_strobe", 8'(load_strobe), 8'd0);
    check("abort_busy", 8'(busy), 8'd0);
    check("abort_owner", 8'(owner), 8'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    req_valid = 2'b11; req_data0 = 4'h3; req_data1 = 4'hC;
    #1 check("post_abort_ready", 8'(req_ready), 8'b01);
    push_word(4'h3, 1'b0);
    @(negedge clk); #1;
    req_valid = 2'b00;

    wait_idle();
    repeat (2) @(negedge clk);
    #4;
    check("bits_left", 8'(bit_q.size()), 8'd0);
    check("owners_left", 8'(owner_q.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
